arith_decoder: RTL and testbench
================================

Name: arith_decoder

Overview:
Integer arithmetic decoder, the receive-side counterpart of the 96-channel arithmetic encoder. It consumes the encoder's serial code bitstream one bit per handshake and reconstructs the 96 three-bit channel symbols of a frame. The word length, frequency table and E1/E2/E3 renormalisation match the encoder bit-exactly. It sits between the serial code input and the downstream symbol consumer.

Parameters:
WORD_BITS, 9, word length of low/up/tag registers (MSB index WORD_BITS-1 = 8)
TOTAL_COUNT, 96, frequency-table total (fixed divisor)
FRAME_SYMBOLS, 96, symbols decoded per frame

Ports:
sys_clk  input  1  system clock, rising edge
sys_reset  input  1  asynchronous active-low reset
start  input  1  one-cycle pulse: begin a new frame (ignored unless IDLE or DONE)
bit_in  input  1  serial code bit, MSB-first as produced by the encoder
bit_valid  input  1  bit_in valid
bit_ready  output  1  decoder accepts bit_in this cycle; transfer = bit_valid & bit_ready
symbol_out  output  3  decoded symbol code
symbol_valid  output  1  one-cycle pulse, symbol_out valid
done  output  1  high from last symbol until next start or reset

Behaviour:
- Clock: one clock, sys_clk. Reset: sys_reset is asynchronous and active-low.
- Fixed cumulative table cum[0..5] = 0, 2, 71, 90, 94, 96. Index k maps to symbol 0→3'b101, 1→3'b000, 2→3'b001, 3→3'b010, 4→3'b011.
- Reset (any time, including mid-frame): state IDLE, low=0, up=511, tag=0, fill count=0, symbol count=0. Outputs: bit_ready=0, symbol_out=0, symbol_valid=0, done=0.
- IDLE: waits for start → FILL.
- FILL: bit_ready=1. On each transfer, tag <= {tag[7:0], bit_in}. After 9 transfers → SEARCH with k=0. low=0 and up=511 on entry.
- SEARCH: one candidate per cycle.
  - range = up-low+1 (10 bits, ≤512).
  - bound_k = low + floor(range*cum[k+1]/96) - 1 (16-bit product, constant divide).
  - If tag ≤ bound_k, or k=4: latch k → UPDATE. Otherwise k <= k+1.
  - Worst case is 5 cycles.
- UPDATE (1 cycle):
  - low <= low + floor(range*cum[k]/96).
  - up <= bound_k.
  - symbol_out <= map(k), symbol_valid=1 for this cycle.
  - symbol count increments.
  - Go to RENORM.
- RENORM: checked once per cycle.
  - E1/E2 (low[8]==up[8]): low <= low<<1, up <= (up<<1)|1, tag <= (tag<<1)|b.
  - Else E3 (low[7]=1 & up[7]=0): same shifts, then bit 8 of low, up and tag is XOR-complemented.
  - Else: if symbol count==96 → DONE; otherwise k=0 → SEARCH.
  - All values are truncated to 9 bits.
  - b is bit_in when a transfer occurs. bit_ready=1 only in RENORM cycles that need a shift. With bit_valid=0 the decoder stalls and holds all state.
- Stream exhaustion is not signalled. Upstream supplies zeros after the encoder's terminating bits.
- DONE: done=1, bit_ready=0. start → clears counters, low=0, up=511, tag=0 → FILL.
- start in FILL/SEARCH/UPDATE/RENORM is ignored.
- symbol_valid is never asserted in consecutive cycles (minimum 2-cycle spacing).
- Simultaneous start and reset: reset wins.

Test Plan:
- Reset mid-RENORM: assert sys_reset low asynchronously → outputs cleared immediately, no symbol_valid; after release and start, decode restarts cleanly.
- Fill 9'b0_0000_0000 → SEARCH matches k=0 (bound 9), symbol_out=3'b101 pulse, low=0, up=9. Then 5 E1 shifts consuming 5 bits, giving up=319.
- Fill 9'b1_1111_1111 → k runs 0..4, symbol_out=3'b011 after 5 SEARCH cycles, low=501, up=511. Then E1 shifts consume bits until MSBs differ.
- Fill 9'b1_0000_0000 (tag=256) → k=1 (bound 377), symbol_out=3'b000, low=10, up=377. No renorm, no bit consumed before next SEARCH.
- Loopback: random 96-symbol frame through the encoder; serialize with bit_valid randomly deasserted 30% of cycles → 96 symbol_valid pulses matching input order, done=1 after the 96th, bit_ready=0 afterward.
- E3 path: stimulus yielding low=0_1xxx, up=1_0xxx → tag bit 8 complemented on shift, decoded sequence still matches the encoder reference. A second start after done decodes a second frame identically.

Source files
------------

// File: rtl/arith_decoder_if.sv
// Handshake bundle between the serial code source, the arithmetic decoder and the symbol consumer.
// The master side drives start and the code bits; the slave side is the decoder.
interface arith_decoder_if;
  logic       start;
  logic       bit_in;
  logic       bit_valid;
  logic       bit_ready;
  logic [2:0] symbol_out;
  logic       symbol_valid;
  logic       done;

  modport master (
    output start, bit_in, bit_valid,
    input  bit_ready, symbol_out, symbol_valid, done
  );

  modport slave (
    input  start, bit_in, bit_valid,
    output bit_ready, symbol_out, symbol_valid, done
  );
endinterface

// File: rtl/arith_decoder.sv
// Integer arithmetic decoder: rebuilds a frame of three-bit channel symbols from the encoder's
// serial code stream using the same word length, frequency table and E1/E2/E3 renormalisation.
module arith_decoder #(
  parameter int WORD_BITS     = 9,
  parameter int TOTAL_COUNT   = 96,
  parameter int FRAME_SYMBOLS = 96
) (
  input logic            sys_clk,
  input logic            sys_reset,
  arith_decoder_if.slave dif
);
  localparam int W   = WORD_BITS;
  localparam int RW  = WORD_BITS + 1;
  localparam int PW  = 16;
  localparam int FCW = $clog2(WORD_BITS + 1);
  localparam int SCW = $clog2(FRAME_SYMBOLS + 1);
  localparam logic [FCW-1:0] FILL_LAST = FCW'(WORD_BITS - 1);
  localparam logic [SCW-1:0] SYM_LAST  = SCW'(FRAME_SYMBOLS);
  localparam logic [W-1:0]   MSB_FLIP  = W'(1) << (W - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_FILL, S_SEARCH, S_UPDATE, S_RENORM, S_DONE
  } state_t;

  state_t         state, state_nxt;
  logic [W-1:0]   low, up, tag;
  logic [FCW-1:0] fill_cnt;
  logic [SCW-1:0] sym_cnt;
  logic [2:0]     k;
  logic [RW-1:0]  range;
  logic [RW-1:0]  bound_k;
  logic [W-1:0]   base_k;
  logic [W-1:0]   flip;
  logic           tag_hit, last_k, e12, e3, need_shift, xfer;
  logic [2:0]     sym_code_p1;
  logic           sym_vld_p1;

  function automatic logic [6:0] cum_at(input logic [2:0] idx);
    case (idx)
      3'd0:    return 7'd0;
      3'd1:    return 7'd2;
      3'd2:    return 7'd71;
      3'd3:    return 7'd90;
      3'd4:    return 7'd94;
      default: return 7'd96;
    endcase
  endfunction

  function automatic logic [2:0] sym_map(input logic [2:0] idx);
    case (idx)
      3'd0:    return 3'b101;
      3'd1:    return 3'b000;
      3'd2:    return 3'b001;
      3'd3:    return 3'b010;
      default: return 3'b011;
    endcase
  endfunction

  // floor(range * cum / TOTAL_COUNT); the product never exceeds 512 * 96 so 16 bits suffice
  function automatic logic [RW-1:0] scale(input logic [RW-1:0] rng, input logic [6:0] c);
    logic [PW-1:0] prod;
    prod = PW'(rng) * PW'(c);
    return RW'(prod / PW'(TOTAL_COUNT));
  endfunction

  always_comb begin
    range      = {1'b0, up} - {1'b0, low} + RW'(1);
    bound_k    = {1'b0, low} + scale(range, cum_at(k + 3'd1)) - RW'(1);
    base_k     = low + W'(scale(range, cum_at(k)));
    tag_hit    = ({1'b0, tag} <= bound_k);
    last_k     = (k == 3'd4);
    e12        = (low[W-1] == up[W-1]);
    e3         = !e12 && low[W-2] && !up[W-2];
    need_shift = e12 || e3;
    flip       = e3 ? MSB_FLIP : '0;
    xfer       = dif.bit_valid && dif.bit_ready;
  end

  always_ff @(posedge sys_clk or negedge sys_reset) begin
    if (!sys_reset) state <= S_IDLE;
    else            state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE, S_DONE: if (dif.start) state_nxt = S_FILL;
      S_FILL:         if (xfer && fill_cnt == FILL_LAST) state_nxt = S_SEARCH;
      S_SEARCH:       if (tag_hit || last_k) state_nxt = S_UPDATE;
      S_UPDATE:       state_nxt = S_RENORM;
      S_RENORM:       if (!need_shift) state_nxt = (sym_cnt == SYM_LAST) ? S_DONE : S_SEARCH;
      default:        state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    dif.bit_ready    = (state == S_FILL) || (state == S_RENORM && need_shift);
    dif.done         = (state == S_DONE);
    dif.symbol_out   = sym_code_p1;
    dif.symbol_valid = sym_vld_p1;
  end

  always_ff @(posedge sys_clk or negedge sys_reset) begin
    if (!sys_reset) begin
      low         <= '0;
      up          <= '1;
      tag         <= '0;
      fill_cnt    <= '0;
      sym_cnt     <= '0;
      k           <= '0;
      sym_code_p1 <= '0;
      sym_vld_p1  <= 1'b0;
    end else begin
      sym_vld_p1 <= 1'b0;
      case (state)
        S_IDLE, S_DONE: begin
          if (dif.start) begin
            low      <= '0;
            up       <= '1;
            tag      <= '0;
            fill_cnt <= '0;
            sym_cnt  <= '0;
            k        <= '0;
          end
        end
        S_FILL: begin
          if (xfer) begin
            tag      <= {tag[W-2:0], dif.bit_in};
            fill_cnt <= fill_cnt + FCW'(1);
          end
        end
        S_SEARCH: begin
          if (!(tag_hit || last_k)) k <= k + 3'd1;
        end
        // symbol decision registered here; symbol_valid leads the first renormalisation cycle
        S_UPDATE: begin
          low         <= base_k;
          up          <= bound_k[W-1:0];
          sym_code_p1 <= sym_map(k);
          sym_vld_p1  <= 1'b1;
          sym_cnt     <= sym_cnt + SCW'(1);
        end
        S_RENORM: begin
          if (need_shift) begin
            if (xfer) begin
              low <= {low[W-2:0], 1'b0} ^ flip;
              up  <= {up[W-2:0], 1'b1} ^ flip;
              tag <= {tag[W-2:0], dif.bit_in} ^ flip;
            end
          end else begin
            k <= '0;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_arith_decoder.sv
// Randomized loopback bench: frames are encoded by a plain-integer arithmetic encoder model and
// the decoder output is compared with the original symbol sequence, plus directed fill cases.
module tb_arith_decoder;
  logic sys_clk = 1'b0;
  logic sys_reset;

  arith_decoder_if dif ();

  arith_decoder dut (
    .sys_clk   (sys_clk),
    .sys_reset (sys_reset),
    .dif       (dif)
  );

  always #5 sys_clk = ~sys_clk;

  int         n_tests = 0;
  int         n_fail  = 0;
  int         cum[6]  = '{0, 2, 71, 90, 94, 96};
  logic [2:0] code_of[5] = '{3'b101, 3'b000, 3'b001, 3'b010, 3'b011};
  bit         frame_bits[$];
  bit         bit_q[$];
  int         exp_sym[96];
  int         got_sym[128];
  int         xfer_at[128];

  task automatic check(input string tag, input int obs, input int exp_v);
    n_tests++;
    if (obs !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp_v);
    end
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_bit_ready"},    dif.bit_ready, 0);
    check({tag, "_symbol_valid"}, dif.symbol_valid, 0);
    check({tag, "_symbol_out"},   dif.symbol_out, 0);
    check({tag, "_done"},         dif.done, 0);
  endtask

  function automatic void emit(input bit b, input int n);
    frame_bits.push_back(b);
    for (int i = 0; i < n; i++) frame_bits.push_back(!b);
  endfunction

  // Textbook integer arithmetic encoder with pending-bit (underflow) handling
  task automatic build_frame(input int mode);
    int lo, hi, pend, rng, k, r;
    frame_bits.delete();
    lo = 0; hi = 511; pend = 0;
    for (int i = 0; i < 96; i++) begin
      if (mode == 0) k = $urandom_range(4);
      else begin
        r = $urandom_range(95);
        k = 0;
        while (r >= cum[k+1]) k++;
      end
      exp_sym[i] = code_of[k];
      rng = hi - lo + 1;
      hi  = lo + (rng * cum[k+1]) / 96 - 1;
      lo  = lo + (rng * cum[k]) / 96;
      forever begin
        if (hi < 256) begin
          emit(1'b0, pend); pend = 0;
        end else if (lo >= 256) begin
          emit(1'b1, pend); pend = 0; lo -= 256; hi -= 256;
        end else if (lo >= 128 && hi < 384) begin
          pend++; lo -= 128; hi -= 128;
        end else break;
        lo = 2 * lo;
        hi = 2 * hi + 1;
      end
    end
    pend++;
    if (lo < 128) emit(1'b0, pend);
    else          emit(1'b1, pend);
  endtask

  task automatic pulse_start();
    dif.start = 1'b1;
    @(posedge sys_clk); #1;
    dif.start = 1'b0;
  endtask

  task automatic apply_reset(input string tag);
    dif.bit_valid = 1'b0;
    #2 sys_reset = 1'b0;
    #1 check_idle(tag);
    @(posedge sys_clk); #1;
    sys_reset = 1'b1;
  endtask

  task automatic stream(input int max_sym, input int stall_pct, input int budget);
    int cyc, got, nx;
    bit prev_sv;
    cyc = 0; got = 0; nx = 0; prev_sv = 1'b0;
    for (int i = 0; i < 128; i++) begin
      got_sym[i] = -1;
      xfer_at[i] = -1;
    end
    while (got < max_sym && cyc < budget) begin
      dif.bit_valid = ($urandom_range(99) >= stall_pct);
      dif.bit_in    = (bit_q.size() > 0) ? bit_q[0] : 1'b0;
      @(negedge sys_clk);
      if (dif.symbol_valid) begin
        check("symbol_valid_spacing", prev_sv, 0);
        got_sym[got] = dif.symbol_out;
        xfer_at[got] = nx;
        got++;
      end
      prev_sv = dif.symbol_valid;
      if (dif.bit_valid && dif.bit_ready) begin
        nx++;
        if (bit_q.size() > 0) void'(bit_q.pop_front());
      end
      @(posedge sys_clk); #1;
      cyc++;
    end
    dif.bit_valid = 1'b0;
    check("stream_symbol_count", got, max_sym);
  endtask

  task automatic directed(input string name, input logic [8:0] fill, input bit filler,
                          input int exp_code, input int exp_gap);
    bit_q.delete();
    for (int i = 8; i >= 0; i--) bit_q.push_back(fill[i]);
    repeat (40) bit_q.push_back(filler);
    pulse_start();
    stream(2, 0, 400);
    check({name, "_symbol"}, got_sym[0], exp_code);
    check({name, "_fill_bits"}, xfer_at[0], 9);
    check({name, "_renorm_bits"}, xfer_at[1] - xfer_at[0], exp_gap);
    apply_reset({name, "_reset"});
  endtask

  task automatic frame_test(input string name, input bit fresh, input int mode, input int stall);
    int extra;
    if (fresh) build_frame(mode);
    bit_q = frame_bits;
    pulse_start();
    stream(96, stall, 20000);
    for (int i = 0; i < 96; i++) check({name, "_symbol"}, got_sym[i], exp_sym[i]);
    dif.bit_valid = 1'b1;
    for (int c = 0; c < 64; c++) begin
      dif.bit_in = (bit_q.size() > 0) ? bit_q[0] : 1'b0;
      @(negedge sys_clk);
      if (dif.done) break;
      if (dif.bit_ready && bit_q.size() > 0) void'(bit_q.pop_front());
      @(posedge sys_clk); #1;
    end
    check({name, "_done"}, dif.done, 1);
    check({name, "_ready_after_done"}, dif.bit_ready, 0);
    extra = 0;
    repeat (6) begin
      @(negedge sys_clk);
      if (dif.symbol_valid) extra++;
    end
    check({name, "_extra_symbols"}, extra, 0);
    @(posedge sys_clk); #1;
    dif.bit_valid = 1'b0;
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int c;
    sys_reset     = 1'b0;
    dif.start     = 1'b0;
    dif.bit_in    = 1'b0;
    dif.bit_valid = 1'b0;
    @(negedge sys_clk);
    check_idle("reset");
    @(posedge sys_clk); #1;
    sys_reset = 1'b1;

    directed("fill_zero", 9'h000, 1'b0, 3'b101, 5);
    directed("fill_ones", 9'h1ff, 1'b1, 3'b011, 5);
    directed("fill_256",  9'h100, 1'b0, 3'b000, 0);

    frame_test("frame_a",        1'b1, 0, 30);
    frame_test("frame_a_repeat", 1'b0, 0, 30);
    frame_test("frame_b",        1'b1, 1, 30);

    build_frame(0);
    bit_q = frame_bits;
    pulse_start();
    stream(3, 30, 4000);
    dif.bit_valid = 1'b0;
    for (c = 0; c < 300; c++) begin
      @(negedge sys_clk);
      if (dif.bit_ready) break;
      @(posedge sys_clk); #1;
    end
    check("renorm_stall_reached", dif.bit_ready, 1);
    #2 sys_reset = 1'b0;
    #1 check_idle("reset_mid_renorm");
    @(posedge sys_clk); #1;
    sys_reset = 1'b1;
    @(negedge sys_clk);
    check_idle("after_reset_release");
    @(posedge sys_clk); #1;

    frame_test("frame_c", 1'b1, 0, 30);
    frame_test("frame_d", 1'b1, 1, 0);
    frame_test("frame_e", 1'b1, 0, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
